regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-side front end for the 32x64 register file. Collects writeback results from `NUM_SRC` functional units over valid/ready handshakes, holds each in a per-source slot, and serializes them round-robin onto the register file's single write port (`RegWrite`/`WriteRegister`/`WriteData`). Writes targeting the zero register X31 are consumed and discarded, never issued. It sits between the execute units and `regfile`.

## Interface
Parameters:
- `NUM_SRC`, 4: number of writeback sources (≥2).
- `DATA_W`, 64: write data width.
- `ADDR_W`, 5: register address width.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: **synchronous, active-high** reset.
- `src_valid`  in  NUM_SRC: source i presents a result.
- `src_ready`  out  NUM_SRC: slot i can accept this cycle.
- `src_reg`  in  NUM_SRC×ADDR_W: destination register per source.
- `src_data`  in  NUM_SRC×DATA_W: result data per source.
- `RegWrite`  out  1: register file write enable (registered).
- `WriteRegister`  out  ADDR_W: register file write address (registered).
- `WriteData`  out  DATA_W: register file write data (registered).
- `pending_mask`  out  32: bit r is set while any full slot targets register r (X31 bit always 0).
- `busy`  out  1: any slot full.
- `zero_drops`  out  8: saturating count of discarded X31 writes.

## Operation
- Each source has a one-entry slot `{full, reg, data}`.
- Accept on source i when `src_valid[i] && src_ready[i]`. The slot loads at the clock edge.
- `src_ready[i] = !reset && (!full[i] || grant[i])`. This is combinational from the grant, so a granted slot can be refilled in the same cycle.
- Arbiter: round-robin over full slots. The search starts at `ptr` and proceeds in increasing index order with wrap.
  - On a grant to index g, `ptr <= (g+1) mod NUM_SRC`.
  - `ptr` holds when there is no grant.
  - At most one grant per cycle. A grant is issued every cycle any slot is full.
- Granted slot with `reg != 31`: the next cycle has `RegWrite=1`, `WriteRegister=reg`, `WriteData=data`.
- Granted slot with `reg == 31`: the slot is freed normally, but the next cycle has `RegWrite=0`. `zero_drops` increments and saturates at 255.
- No grant: the next cycle has `RegWrite=0`. `WriteRegister` and `WriteData` hold their last values.
- Ordering: per source, writes issue in acceptance order. Across sources, order is arbiter order only. The issuing stage must not have two in-flight writes to the same register from different sources; `pending_mask` is provided for that check.
- `pending_mask` and `busy` are combinational from slot state, which excludes the output register.

## Timing
- Latency is fixed at 2: accepted at edge E0, slot full in cycle 1, granted (if uncontended) in cycle 1, `RegWrite` high in cycle 2, register file updated at the end of cycle 2.
- Worst-case wait from slot full to grant is NUM_SRC−1 cycles.
- Throughput: one write per cycle sustained. One source can stream at one per cycle only when it is uncontended.
- Simultaneous grant and accept on the same slot: the new value is loaded and the slot stays full. No bubble.
- Reset (sync, any cycle including mid-stream):
  - All slots are emptied.
  - `ptr=0`, `RegWrite=0`, `WriteRegister=0`, `WriteData=0`, `zero_drops=0`.
  - `src_ready=0` while `reset` is high.
  - Data in flight is discarded. No write issues in the cycle after reset deasserts.

## Structure
- Package `wb_pkg`:
  - constant `ZERO_REG = 5'd31`
  - typedef `wb_req_t {logic [ADDR_W-1:0] reg; logic [DATA_W-1:0] data;}` (default widths 5/64)
  - function `rr_next(ptr, g)`
- Sub-module `rr_arbiter #(N)`:
  - inputs `req[N]`, `ptr`
  - outputs one-hot `grant[N]`, `grant_idx`, `grant_valid`
  - purely combinational
  - `ptr` register lives in the parent

## Test plan
- Single write: src0 sends reg 5, data `0xDEADBEEF00000001` at cycle 0. Required: `RegWrite=1`, `WriteRegister=5` and that data in cycle 2 only. The downstream `regfile` read of X5 returns the data.
- Fairness: all 4 sources are valid at cycle 0 with regs 1–4, and src0 stays valid with new regs. Required: issue order reg 1, 2, 3, 4, then src0's next. No source waits more than 3 cycles.
- Zero register: src2 sends reg 31, data `0xA0`. Required: the slot frees, `RegWrite` stays 0, `zero_drops=1`. After 300 such writes, `zero_drops=255`.
- Streaming refill: src1 is valid every cycle with regs 0..7 and no other traffic. Required: `src_ready[1]` stays high, and 8 consecutive `RegWrite` cycles occur in order.
- Pending mask: src3 holds reg 9 while blocked behind 3 full slots. Required: `pending_mask[9]=1` until its grant cycle, then 0. `busy` falls when all slots drain.
- Reset mid-operation: assert `reset` for one cycle with 3 slots full. Required: next cycle `RegWrite=0`, `busy=0`, `src_ready=0` during reset, no stale write afterwards, and `ptr` restarts at 0.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants, request record and round-robin pointer helper for the
// register-file writeback arbiter.
package wb_pkg;

    localparam int WB_ADDR_W = 5;
    localparam int WB_DATA_W = 64;

    localparam logic [4:0] ZERO_REG = 5'd31;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] waddr;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

    // Pointer moves to the slot after the winner; it holds when nothing is granted.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned g,
                                            input logic gv, input int unsigned n);
        if (!gv) begin
            return ptr;
        end
        return (g + 32'd1 >= n) ? 32'd0 : g + 32'd1;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback source handshakes plus the register file write port.
interface regfile_wb_arbiter_if #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 5
) ();

    logic [NUM_SRC-1:0]             src_valid;
    logic [NUM_SRC-1:0]             src_ready;
    logic [NUM_SRC-1:0][ADDR_W-1:0] src_reg;
    logic [NUM_SRC-1:0][DATA_W-1:0] src_data;

    logic                           RegWrite;
    logic [ADDR_W-1:0]              WriteRegister;
    logic [DATA_W-1:0]              WriteData;

    modport slave (
        input  src_valid, src_reg, src_data,
        output src_ready, RegWrite, WriteRegister, WriteData
    );

    modport master (
        output src_valid, src_reg, src_data,
        input  src_ready, RegWrite, WriteRegister, WriteData
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins,
// searching upward with wrap. The pointer register belongs to the parent.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_valid
);

    logic [IW:0] sum;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        sum         = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            if (!grant_valid && req[sum[IW-1:0]]) begin
                grant_valid           = 1'b1;
                grant_idx             = sum[IW-1:0];
                grant[sum[IW-1:0]]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Collects writeback results into per-source slots and serializes them
// round-robin onto the register file write port, discarding X31 writes.
module regfile_wb_arbiter
    import wb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 5
) (
    input  logic                clk,
    input  logic                reset,
    regfile_wb_arbiter_if.slave bus,
    output logic [31:0]         pending_mask,
    output logic                busy,
    output logic [7:0]          zero_drops
);

    localparam int              PW = $clog2(NUM_SRC);
    localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);

    logic              full_q [NUM_SRC];
    logic [ADDR_W-1:0] reg_q  [NUM_SRC];
    logic [DATA_W-1:0] data_q [NUM_SRC];

    wire  [NUM_SRC-1:0] full_vec;
    wire  [NUM_SRC-1:0] accept;
    wire  [31:0]        slot_mask [NUM_SRC];
    wire  [31:0]        mask_acc  [NUM_SRC+1];

    logic [NUM_SRC-1:0] grant;
    logic [PW-1:0]      grant_idx;
    logic               grant_valid;

    logic [PW-1:0]      ptr_q, ptr_d;
    logic               rw_q, rw_d;
    logic [ADDR_W-1:0]  wr_q, wr_d;
    logic [DATA_W-1:0]  wd_q, wd_d;
    logic [7:0]         zd_q, zd_d;
    logic [ADDR_W-1:0]  sel_reg;
    logic [DATA_W-1:0]  sel_data;

    // A granted slot frees this cycle, so it may take a new result at the same edge.
    assign bus.src_ready = reset ? '0 : (~full_vec | grant);

    assign mask_acc[0] = '0;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_slot
            assign full_vec[gi]  = full_q[gi];
            assign accept[gi]    = bus.src_valid[gi] & bus.src_ready[gi];
            assign slot_mask[gi] = (full_q[gi] && reg_q[gi] != ZR) ? (32'd1 << reg_q[gi]) : 32'd0;
            assign mask_acc[gi+1] = mask_acc[gi] | slot_mask[gi];

            always_ff @(posedge clk) begin
                if (reset) begin
                    full_q[gi] <= 1'b0;
                    reg_q[gi]  <= '0;
                    data_q[gi] <= '0;
                end else if (accept[gi]) begin
                    full_q[gi] <= 1'b1;
                    reg_q[gi]  <= bus.src_reg[gi];
                    data_q[gi] <= bus.src_data[gi];
                end else if (grant[gi]) begin
                    full_q[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    rr_arbiter #(.N(NUM_SRC)) u_arb (
        .req         (full_vec),
        .ptr         (ptr_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        sel_reg  = reg_q[grant_idx];
        sel_data = data_q[grant_idx];
        rw_d     = 1'b0;
        wr_d     = wr_q;
        wd_d     = wd_q;
        zd_d     = zd_q;
        if (grant_valid) begin
            if (sel_reg == ZR) begin
                if (zd_q != 8'hFF) begin
                    zd_d = zd_q + 8'd1;
                end
            end else begin
                rw_d = 1'b1;
                wr_d = sel_reg;
                wd_d = sel_data;
            end
        end
        ptr_d = PW'(rr_next(32'(ptr_q), 32'(grant_idx), grant_valid, 32'(NUM_SRC)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
            rw_q  <= 1'b0;
            wr_q  <= '0;
            wd_q  <= '0;
            zd_q  <= '0;
        end else begin
            ptr_q <= ptr_d;
            rw_q  <= rw_d;
            wr_q  <= wr_d;
            wd_q  <= wd_d;
            zd_q  <= zd_d;
        end
    end

    assign bus.RegWrite      = rw_q;
    assign bus.WriteRegister = wr_q;
    assign bus.WriteData     = wd_q;
    assign pending_mask      = mask_acc[NUM_SRC];
    assign busy              = |full_vec;
    assign zero_drops        = zd_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for the writeback arbiter: vector table of isolated writes plus
// hand-built multi-cycle sequences, all issued writes checked via a scoreboard.
module tb_regfile_wb_arbiter;
    import wb_pkg::*;

    localparam int NS = 4;
    localparam int DW = 64;
    localparam int AW = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pending_mask;
    logic        busy;
    logic [7:0]  zero_drops;

    regfile_wb_arbiter_if #(.NUM_SRC(NS), .DATA_W(DW), .ADDR_W(AW)) bus ();

    regfile_wb_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .pending_mask (pending_mask),
        .busy         (busy),
        .zero_drops   (zero_drops)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  src;
        logic [4:0]  r;
        logic [63:0] d;
        logic        exp_rw;
        logic [4:0]  exp_wr;
        logic [63:0] exp_wd;
        logic [7:0]  exp_zd;
    } vec_t;

    int          checks    = 0;
    int          failures  = 0;
    int          cyc       = 0;
    int          rw_count  = 0;
    int          rw0;
    wb_req_t     sb [$];
    logic [63:0] rf [32];
    vec_t        vec [7];
    logic [31:0] pm_exp [4];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    task automatic tick();
        wb_req_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.RegWrite === 1'b1) begin
            rw_count++;
            rf[bus.WriteRegister] = bus.WriteData;
            $display("cyc=%0d write reg=%0d data=%h", cyc, bus.WriteRegister, bus.WriteData);
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_write cyc=%0d got reg=%0d expected no write", cyc, bus.WriteRegister);
            end else begin
                e = sb.pop_front();
                chk("sb_reg", 64'(bus.WriteRegister), 64'(e.waddr));
                chk("sb_data", bus.WriteData, e.data);
            end
        end
    endtask

    task automatic clear_inputs();
        bus.src_valid = '0;
        bus.src_reg   = '0;
        bus.src_data  = '0;
    endtask

    task automatic drive(input logic [1:0] s, input logic [4:0] r, input logic [63:0] d);
        bus.src_valid[s] = 1'b1;
        bus.src_reg[s]   = r;
        bus.src_data[s]  = d;
    endtask

    task automatic exp_push(input logic [4:0] r, input logic [63:0] d);
        wb_req_t e;
        if (r != ZERO_REG) begin
            e.waddr = r;
            e.data  = d;
            sb.push_back(e);
        end
    endtask

    task automatic reset_dut();
        chk("sb_drained", 64'(sb.size()), 64'd0);
        clear_inputs();
        reset = 1'b1;
        #1;
        chk("rst_ready_low", 64'(bus.src_ready), 64'd0);
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        for (int r = 0; r < 32; r++) rf[r] = '0;

        vec[0] = '{2'd0, 5'd5,  64'hDEADBEEF00000001, 1'b1, 5'd5,  64'hDEADBEEF00000001, 8'd0};
        vec[1] = '{2'd1, 5'd0,  64'h0123456789ABCDEF, 1'b1, 5'd0,  64'h0123456789ABCDEF, 8'd0};
        vec[2] = '{2'd2, 5'd31, 64'h00000000000000A0, 1'b0, 5'd0,  64'h0123456789ABCDEF, 8'd1};
        vec[3] = '{2'd3, 5'd30, 64'hFFFFFFFFFFFFFFFF, 1'b1, 5'd30, 64'hFFFFFFFFFFFFFFFF, 8'd1};
        vec[4] = '{2'd2, 5'd7,  64'h55AA55AA55AA55AA, 1'b1, 5'd7,  64'h55AA55AA55AA55AA, 8'd1};
        vec[5] = '{2'd1, 5'd31, 64'h0000000000001234, 1'b0, 5'd7,  64'h55AA55AA55AA55AA, 8'd2};
        vec[6] = '{2'd0, 5'd1,  64'h8000000000000001, 1'b1, 5'd1,  64'h8000000000000001, 8'd2};

        pm_exp[0] = 32'h0000_1E00;
        pm_exp[1] = 32'h0000_1A00;
        pm_exp[2] = 32'h0000_1200;
        pm_exp[3] = 32'h0000_0200;

        // Power-on reset state
        tick();
        tick();
        chk("rst_ready_low", 64'(bus.src_ready), 64'd0);
        reset = 1'b0;
        #1;
        chk("rst_regwrite", 64'(bus.RegWrite), 64'd0);
        chk("rst_wreg", 64'(bus.WriteRegister), 64'd0);
        chk("rst_wdata", bus.WriteData, 64'd0);
        chk("rst_zero_drops", 64'(zero_drops), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pending", 64'(pending_mask), 64'd0);
        chk("idle_ready", 64'(bus.src_ready), 64'hF);

        // Isolated single writes, latency 2 from acceptance
        for (int i = 0; i < 7; i++) begin
            drive(vec[i].src, vec[i].r, vec[i].d);
            exp_push(vec[i].r, vec[i].d);
            chk("vec_ready", 64'(bus.src_ready[vec[i].src]), 64'd1);
            tick();
            clear_inputs();
            chk("vec_busy", 64'(busy), 64'd1);
            chk("vec_pmask", 64'(pending_mask),
                (vec[i].r == 5'd31) ? 64'd0 : (64'd1 << vec[i].r));
            chk("vec_rw_early", 64'(bus.RegWrite), 64'd0);
            tick();
            chk("vec_rw", 64'(bus.RegWrite), 64'(vec[i].exp_rw));
            chk("vec_wreg", 64'(bus.WriteRegister), 64'(vec[i].exp_wr));
            chk("vec_wdata", bus.WriteData, vec[i].exp_wd);
            chk("vec_zero_drops", 64'(zero_drops), 64'(vec[i].exp_zd));
            chk("vec_busy_free", 64'(busy), 64'd0);
            tick();
            chk("vec_rw_late", 64'(bus.RegWrite), 64'd0);
        end
        chk("rf_x5", rf[5], 64'hDEADBEEF00000001);

        // Fairness: all four sources at once, src0 keeps offering
        reset_dut();
        for (int s = 0; s < 4; s++) begin
            drive(2'(s), 5'(s + 1), 64'hF0F0_0000_0000_0000 | 64'(s + 1));
            exp_push(5'(s + 1), 64'hF0F0_0000_0000_0000 | 64'(s + 1));
        end
        #1;
        chk("fair_ready_all", 64'(bus.src_ready), 64'hF);
        tick();
        clear_inputs();
        drive(2'd0, 5'd5, 64'h0000_0000_0000_FA05);
        exp_push(5'd5, 64'h0000_0000_0000_FA05);
        #1;
        chk("fair_refill_ready", 64'(bus.src_ready[0]), 64'd1);
        rw0 = rw_count;
        tick();
        chk("fair_first_write", 64'(bus.RegWrite), 64'd1);
        drive(2'd0, 5'd6, 64'h0000_0000_0000_FA06);
        exp_push(5'd6, 64'h0000_0000_0000_FA06);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("fair_src0_blocked", 64'(bus.src_ready[0]), 64'd0);
            tick();
        end
        chk("fair_src0_turn", 64'(bus.src_ready[0]), 64'd1);
        tick();
        clear_inputs();
        tick();
        tick();
        chk("fair_write_count", 64'(rw_count - rw0), 64'd6);
        chk("fair_idle", 64'(bus.RegWrite), 64'd0);
        chk("fair_busy_low", 64'(busy), 64'd0);

        // Streaming refill on one uncontended source
        rw0 = rw_count;
        for (int k = 0; k < 8; k++) begin
            drive(2'd1, 5'(k), 64'h0000_0000_0000_5100 | 64'(k));
            exp_push(5'(k), 64'h0000_0000_0000_5100 | 64'(k));
            #1;
            chk("stream_ready", 64'(bus.src_ready[1]), 64'd1);
            tick();
            chk("stream_rw", 64'(bus.RegWrite), (k > 0) ? 64'd1 : 64'd0);
        end
        clear_inputs();
        tick();
        chk("stream_rw_last", 64'(bus.RegWrite), 64'd1);
        tick();
        chk("stream_rw_end", 64'(bus.RegWrite), 64'd0);
        chk("stream_count", 64'(rw_count - rw0), 64'd8);

        // Zero-register drops and counter saturation
        reset_dut();
        for (int i = 0; i < 300; i++) begin
            drive(2'd2, 5'd31, 64'h0000_0000_0000_00A0);
            #1;
            if (i < 3) chk("zero_ready", 64'(bus.src_ready[2]), 64'd1);
            tick();
            if (i == 1)   chk("zero_one", 64'(zero_drops), 64'd1);
            if (i == 254) chk("zero_254", 64'(zero_drops), 64'd254);
            if (i == 256) chk("zero_sat_early", 64'(zero_drops), 64'd255);
        end
        clear_inputs();
        tick();
        tick();
        chk("zero_sat", 64'(zero_drops), 64'd255);
        chk("zero_busy_low", 64'(busy), 64'd0);
        chk("zero_no_write", 64'(bus.RegWrite), 64'd0);

        // Pending mask while src3 waits behind three full slots
        reset_dut();
        drive(2'd0, 5'd10, 64'h0000_0000_0000_0A0A);
        drive(2'd1, 5'd11, 64'h0000_0000_0000_0B0B);
        drive(2'd2, 5'd12, 64'h0000_0000_0000_0C0C);
        drive(2'd3, 5'd9,  64'h0000_0000_0000_0909);
        exp_push(5'd10, 64'h0000_0000_0000_0A0A);
        exp_push(5'd11, 64'h0000_0000_0000_0B0B);
        exp_push(5'd12, 64'h0000_0000_0000_0C0C);
        exp_push(5'd9,  64'h0000_0000_0000_0909);
        tick();
        clear_inputs();
        for (int k = 0; k < 4; k++) begin
            chk("pend_mask", 64'(pending_mask), 64'(pm_exp[k]));
            chk("pend_bit9", 64'(pending_mask[9]), 64'd1);
            chk("pend_busy", 64'(busy), 64'd1);
            tick();
        end
        chk("pend_mask_clear", 64'(pending_mask), 64'd0);
        chk("pend_busy_low", 64'(busy), 64'd0);

        // Reset with three slots full
        reset_dut();
        drive(2'd0, 5'd1, 64'h0000_0000_0000_DD01);
        drive(2'd1, 5'd2, 64'h0000_0000_0000_DD02);
        drive(2'd2, 5'd3, 64'h0000_0000_0000_DD03);
        tick();
        clear_inputs();
        chk("mid_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("mid_ready_in_reset", 64'(bus.src_ready), 64'd0);
        tick();
        reset = 1'b0;
        chk("mid_rw_after", 64'(bus.RegWrite), 64'd0);
        chk("mid_busy_after", 64'(busy), 64'd0);
        chk("mid_pending_after", 64'(pending_mask), 64'd0);
        chk("mid_wreg_after", 64'(bus.WriteRegister), 64'd0);
        chk("mid_wdata_after", bus.WriteData, 64'd0);
        tick();
        chk("mid_no_stale", 64'(bus.RegWrite), 64'd0);
        drive(2'd1, 5'd21, 64'h0000_0000_0000_EE21);
        drive(2'd0, 5'd20, 64'h0000_0000_0000_EE20);
        exp_push(5'd20, 64'h0000_0000_0000_EE20);
        exp_push(5'd21, 64'h0000_0000_0000_EE21);
        tick();
        clear_inputs();
        tick();
        chk("mid_ptr0_first", 64'(bus.WriteRegister), 64'd20);
        tick();
        chk("mid_ptr0_second", 64'(bus.WriteRegister), 64'd21);
        tick();
        chk("sb_final_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
